// File: rtl/restoring_divider_16_bit.sv
// 16-bit unsigned restoring divider: one quotient bit per clock, trial subtraction
// on a hierarchical carry-lookahead adder, with a start/busy/done handshake.

module CLA_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       p_out,
    output logic       g_out
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
        sum  = p ^ c;
        p_out = &p;
        g_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end
endmodule

module CLA_16_bit #(
    parameter int NUM_LANES = 4
) (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        bp,
    output logic        bg
);
    logic [NUM_LANES-1:0][3:0] a_l;
    logic [NUM_LANES-1:0][3:0] b_l;
    logic [NUM_LANES-1:0][3:0] s_l;
    logic [NUM_LANES-1:0]      gp;
    logic [NUM_LANES-1:0]      gg;
    logic [NUM_LANES-1:0]      gc;

    assign a_l = a;
    assign b_l = b;
    assign sum = s_l;

    // Second-level lookahead: block carries straight from group P/G, no ripple.
    always_comb begin
        gc[0] = c_in;
        gc[1] = gg[0] | (gp[0] & c_in);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c_in);
        bp    = &gp;
        bg    = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        CLA_4_bit u_cla4 (
            .a     (a_l[i]),
            .b     (b_l[i]),
            .c_in  (gc[i]),
            .sum   (s_l[i]),
            .p_out (gp[i]),
            .g_out (gg[i])
        );
    end
endmodule

module restoring_divider_16_bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] dvs_q,       dvs_d;
    logic [WIDTH-1:0] qr_q,        qr_d;
    // The partial remainder is 17 bits wide during the trial, but after every
    // iteration it is below the divisor, so its top bit is always 0 and not stored.
    logic [WIDTH-1:0] r_q,         r_d;
    logic [3:0]       cnt_q,       cnt_d;
    logic [WIDTH-1:0] quot_q,      quot_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic             dbz_q,       dbz_d;

    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] diff;
    logic             bp, bg, c16, t16;

    assign s   = {r_q, qr_q[WIDTH-1]};
    assign c16 = bg | (bp & 1'b1);
    assign t16 = s[WIDTH] ^ 1'b1 ^ c16;

    CLA_16_bit u_sub (
        .a    (s[WIDTH-1:0]),
        .b    (~dvs_q),
        .c_in (1'b1),
        .sum  (diff),
        .bp   (bp),
        .bg   (bg)
    );

    always_comb begin
        state_d = state_q;
        dvs_d   = dvs_q;
        qr_d    = qr_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            RUN: begin
                if (!t16) begin
                    r_d  = diff;
                    qr_d = {qr_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d  = s[WIDTH-1:0];
                    qr_d = {qr_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = DONE;
                    quot_d  = qr_d;
                    rem_d   = r_d;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE otherwise falls to IDLE.
                state_d = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvs_d   = divisor;
                        qr_d    = dividend;
                        r_d     = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dvs_q   <= '0;
            qr_q    <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvs_q   <= dvs_d;
            qr_q    <= qr_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider_16_bit.sv
// Bench for restoring_divider_16_bit: directed scenarios plus a randomized
// back-to-back sweep checked against plain '/' and '%' arithmetic.

module tb_restoring_divider_16_bit;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int npass;
    int ntotal;

    restoring_divider_16_bit #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
        return (b == 16'd0) ? 16'hFFFF : a / b;
    endfunction

    function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
        return (b == 16'd0) ? a : a % b;
    endfunction

    function automatic int ref_lat(input logic [15:0] b);
        return (b == 16'd0) ? 1 : 17;
    endfunction

    // Issue one request and wait (bounded) for done; lat counts cycles from start.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int busy_cycles);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #3;
        ntotal++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        else npass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ntotal++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        else npass++;
    endtask

    task automatic test_basic;
        int lat, bc;
        run_op(16'd100, 16'd7, lat, bc);
        ntotal++;
        if (lat !== 17) $display("FAIL basic_latency: got %0d want 17", lat); else npass++;
        ntotal++;
        if (bc !== 16) $display("FAIL basic_busy_cycles: got %0d want 16", bc); else npass++;
        ntotal++;
        if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", busy); else npass++;
        ntotal++;
        if (quotient !== ref_q(16'd100, 16'd7) || remainder !== ref_r(16'd100, 16'd7) || div_by_zero !== 1'b0)
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want q=14 r=2 dbz=0",
                     quotient, remainder, div_by_zero);
        else npass++;
        @(negedge clk);
        ntotal++;
        if (done !== 1'b0 || quotient !== 16'd14 || remainder !== 16'd2)
            $display("FAIL basic_hold: got done=%b q=%0d r=%0d want done=0 q=14 r=2",
                     done, quotient, remainder);
        else npass++;
    endtask

    task automatic test_wide;
        int lat, bc;
        run_op(16'hFFFF, 16'h0001, lat, bc);
        ntotal++;
        if (lat !== 17 || quotient !== 16'hFFFF || remainder !== 16'h0000)
            $display("FAIL wide_ffff_by_1: got lat=%0d q=%h r=%h want lat=17 q=ffff r=0000",
                     lat, quotient, remainder);
        else npass++;
        run_op(16'h8000, 16'h8001, lat, bc);
        ntotal++;
        if (lat !== 17 || quotient !== 16'h0000 || remainder !== 16'h8000)
            $display("FAIL wide_8000_by_8001: got lat=%0d q=%h r=%h want lat=17 q=0000 r=8000",
                     lat, quotient, remainder);
        else npass++;
        run_op(16'hFFFF, 16'hFFFE, lat, bc);
        ntotal++;
        if (quotient !== ref_q(16'hFFFF, 16'hFFFE) || remainder !== ref_r(16'hFFFF, 16'hFFFE))
            $display("FAIL wide_ffff_by_fffe: got q=%h r=%h want q=0001 r=0001", quotient, remainder);
        else npass++;
    endtask

    task automatic test_div_zero;
        int lat, bc;
        run_op(16'd5, 16'd0, lat, bc);
        ntotal++;
        if (lat !== 1 || bc !== 0)
            $display("FAIL dbz_timing: got lat=%0d busy_cycles=%0d want 1 0", lat, bc);
        else npass++;
        ntotal++;
        if (quotient !== 16'hFFFF || remainder !== 16'd5 || div_by_zero !== 1'b1)
            $display("FAIL dbz_result: got q=%h r=%0d dbz=%b want q=ffff r=5 dbz=1",
                     quotient, remainder, div_by_zero);
        else npass++;
        run_op(16'd9, 16'd3, lat, bc);
        ntotal++;
        if (quotient !== 16'd3 || remainder !== 16'd0 || div_by_zero !== 1'b0)
            $display("FAIL dbz_cleared: got q=%0d r=%0d dbz=%b want q=3 r=0 dbz=0",
                     quotient, remainder, div_by_zero);
        else npass++;
    endtask

    task automatic test_start_ignored;
        int lat;
        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (lat == 5) begin
                dividend = 16'd7; divisor = 16'd7; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        ntotal++;
        if (lat !== 17 || quotient !== 16'd100 || remainder !== 16'd0)
            $display("FAIL start_in_run: got lat=%0d q=%0d r=%0d want lat=17 q=100 r=0",
                     lat, quotient, remainder);
        else npass++;
    endtask

    task automatic test_reset_abort;
        int lat, bc;
        logic saw_done;
        @(negedge clk);
        dividend = 16'hBEEF; divisor = 16'h0013; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        ntotal++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0)
            $display("FAIL abort_async: got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        else npass++;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        ntotal++;
        if (saw_done !== 1'b0) $display("FAIL abort_no_done: got done pulse want none"); else npass++;
        run_op(16'hBEEF, 16'h0013, lat, bc);
        ntotal++;
        if (lat !== 17 || quotient !== ref_q(16'hBEEF, 16'h0013) || remainder !== ref_r(16'hBEEF, 16'h0013))
            $display("FAIL abort_rerun: got lat=%0d q=%h r=%h want lat=17 q=%h r=%h", lat,
                     quotient, remainder, ref_q(16'hBEEF, 16'h0013), ref_r(16'hBEEF, 16'h0013));
        else npass++;
    endtask

    task automatic test_back_to_back;
        localparam int N = 1500;
        logic [15:0] av [N];
        logic [15:0] bv [N];
        int lat, sel;
        for (int i = 0; i < N; i++) begin
            av[i] = 16'($urandom);
            sel   = int'($urandom_range(0, 9));
            if (sel == 0)      bv[i] = 16'd0;
            else if (sel == 1) bv[i] = 16'($urandom_range(1, 15));
            else if (sel == 2) bv[i] = av[i];
            else               bv[i] = 16'($urandom);
            if (sel == 3) av[i] = 16'hFFFF;
        end
        @(negedge clk);
        dividend = av[0]; divisor = bv[0]; start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            lat = 1;
            while (!done && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            ntotal++;
            if (lat !== ref_lat(bv[i]))
                $display("FAIL b2b_spacing[%0d]: got %0d want %0d (a=%h b=%h)", i, lat,
                         ref_lat(bv[i]), av[i], bv[i]);
            else npass++;
            ntotal++;
            if (quotient !== ref_q(av[i], bv[i]) || remainder !== ref_r(av[i], bv[i]) ||
                div_by_zero !== (bv[i] == 16'd0))
                $display("FAIL b2b_result[%0d]: a=%h b=%h got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                         i, av[i], bv[i], quotient, remainder, div_by_zero,
                         ref_q(av[i], bv[i]), ref_r(av[i], bv[i]), bv[i] == 16'd0);
            else npass++;
            if (lat >= 40) break;
            if (i + 1 < N) begin
                dividend = av[i+1]; divisor = bv[i+1];
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        npass = 0;
        ntotal = 0;
        test_reset();
        test_basic();
        test_wide();
        test_div_zero();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
